// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready pipeline stage: DEPTH-entry FIFO with a NOP bubble when empty and a synchronous flush.
// Optional back-pressure/starvation counters are enabled with `define PIPE_STAGE_STATS_EN.
module pipe_stage_fifo #(
   parameter int unsigned       DATA_W  = 128,
   parameter int unsigned       DEPTH   = 2,
   parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_up_vld,
   output logic                     o_up_rdy,
   input  logic [DATA_W-1:0]        i_up_data,
   output logic                     o_dn_vld,
   input  logic                     i_dn_rdy,
   output logic [DATA_W-1:0]        o_dn_data,
`ifdef PIPE_STAGE_STATS_EN
   input  logic                     i_stats_clr,
   output logic [31:0]              o_stall_cnt,
   output logic [31:0]              o_bubble_cnt,
`endif
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop;

   // Ready and valid come only from registered occupancy, so no combinational path crosses the stage.
   assign o_up_rdy  = (count_q != CW'(DEPTH));
   assign o_dn_vld  = (count_q != '0);
   assign push      = i_up_vld & o_up_rdy;
   assign pop       = o_dn_vld & i_dn_rdy;
   assign o_dn_data = o_dn_vld ? mem_q[rd_ptr_q] : NOP_VAL;
   assign o_count   = count_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; count alone decides whether an entry is visible.
   always_ff @(posedge i_clk) begin
      if (push && !i_flush) mem_q[wr_ptr_q] <= i_up_data;
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (i_stats_clr) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (i_up_vld && !o_up_rdy && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (i_dn_rdy && !o_dn_vld && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
   end

   assign o_stall_cnt  = stall_cnt_q;
   assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule
